// File: rtl/mmio_bus_unit.sv
// MEM-stage bus unit: routes loads/stores/ecalls to data memory or memory-mapped IO.
// Optional build macro MMIO_BTN_STICKY_EN turns the button into a sticky, read-to-clear flag.
module mmio_bus_unit #(
  parameter logic [31:0] IO_BASE       = 32'hFFFF_FF00,
  parameter int          MEM_LAT       = 2,
  parameter int          SW_W          = 12,
  parameter int          LED_W         = 16,
  parameter logic [11:0] EOP_PRINT_INT = 12'd1,
  parameter logic [11:0] EOP_READ_INT  = 12'd5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_read,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic             ecall_read,
  input  logic             ecall_write,
  input  logic [11:0]      ecall_op,
  input  logic [31:0]      ecall_a0,
  output logic             stall,
  output logic             rsp_valid,
  output logic [31:0]      rsp_data,
  output logic             mem_en,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic [SW_W-1:0]  switch_in,
  input  logic             btn_in,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic [LED_W-1:0] led_out,
  output logic [31:0]      seg_out,
  output logic             io_err,
  output logic [1:0]       dbg_state
);

  // Handshake: a request is taken in the one IDLE cycle it is seen; the MEM stage must
  // hold it while stall=1, and rsp_valid marks the single cycle rsp_data is write-back data.
  typedef enum logic [1:0] {IDLE = 2'd0, MEM_WAIT = 2'd1, RESP = 2'd2} state_t;

  localparam logic [2:0] LAST_CNT = 3'(MEM_LAT - 1);

  state_t      state, state_next;
  logic [2:0]  cnt;
  logic        key_ready;
  logic [3:0]  key_reg;
  logic        btn_s1, btn_s2;
  logic        btn_bit;
  logic        is_io, idle, mapped;
  logic [7:0]  off;
  logic        mem_rd, io_rd, ec_rd, mem_wr, io_wr, ec_wr;
  logic        key_rd, btn_rd, mem_done;
  logic [31:0] io_rdata;
  logic        unused_a0;

  assign unused_a0 = ^ecall_a0[31:LED_W];

  assign is_io  = (req_addr[31:8] == IO_BASE[31:8]);
  assign off    = req_addr[7:0];
  assign idle   = (state == IDLE);
  assign mem_rd = idle & req_read & ~is_io;
  assign io_rd  = idle & req_read & is_io;
  assign ec_rd  = idle & ecall_read & (ecall_op == EOP_READ_INT);
  assign mem_wr = idle & req_write & ~is_io;
  assign io_wr  = idle & req_write & is_io;
  assign ec_wr  = idle & ecall_write & (ecall_op == EOP_PRINT_INT);
  assign key_rd = io_rd & (off == 8'h08);
  assign btn_rd = io_rd & (off == 8'h04);

  // Memory read data is sampled on the edge that closes the last wait cycle.
  assign mem_done = (MEM_LAT == 1) ? mem_rd : ((state == MEM_WAIT) && (cnt == LAST_CNT));

  assign stall     = mem_rd | io_rd | ec_rd | (state == MEM_WAIT);
  assign rsp_valid = (state == RESP);
  assign mem_en    = mem_rd | mem_wr;
  assign mem_we    = mem_wr;
  assign mem_addr  = req_addr;
  assign mem_wdata = req_wdata;
  assign dbg_state = state;

  always_comb begin
    mapped   = 1'b1;
    io_rdata = 32'd0;
    case (off)
      8'h00:   io_rdata = {{(32-SW_W){1'b0}}, switch_in};
      8'h04:   io_rdata = {31'd0, btn_bit};
      8'h08:   io_rdata = {27'd0, key_ready, key_reg};
      8'h10:   io_rdata = 32'd0;
      8'h14:   io_rdata = 32'd0;
      8'h18:   io_rdata = {30'd0, key_ready, btn_bit};
      default: mapped = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (mem_rd)              state_next = (MEM_LAT == 1) ? RESP : MEM_WAIT;
        else if (io_rd || ec_rd) state_next = RESP;
      end
      MEM_WAIT: if (cnt == LAST_CNT) state_next = RESP;
      RESP:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      rsp_data <= 32'd0;
    end else begin
      state <= state_next;
      if (mem_rd)                 cnt <= 3'd1;
      else if (state == MEM_WAIT) cnt <= cnt + 3'd1;
      if (mem_done)               rsp_data <= mem_rdata;
      else if (io_rd)             rsp_data <= mapped ? io_rdata : 32'd0;
      else if (ec_rd)             rsp_data <= {{(32-SW_W){1'b0}}, switch_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_out   <= '0;
      seg_out   <= 32'd0;
      io_err    <= 1'b0;
      key_reg   <= 4'd0;
      key_ready <= 1'b0;
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
    end else begin
      btn_s1 <= btn_in;
      btn_s2 <= btn_s1;
      if (io_wr && off == 8'h10) led_out <= req_wdata[LED_W-1:0];
      else if (ec_wr)            led_out <= ecall_a0[LED_W-1:0];
      if (io_wr && off == 8'h14) seg_out <= req_wdata;
      if ((io_rd || io_wr) && !mapped) io_err <= 1'b1;
      // A new key wins over a simultaneous read's clear, so the fresh code is not lost.
      if (key_valid) begin
        key_reg   <= key_code;
        key_ready <= 1'b1;
      end else if (key_rd) begin
        key_ready <= 1'b0;
      end
    end
  end

`ifdef MMIO_BTN_STICKY_EN
  logic btn_s3, btn_flag;
  assign btn_bit = btn_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s3   <= 1'b0;
      btn_flag <= 1'b0;
    end else begin
      btn_s3 <= btn_s2;
      if (btn_s2 && !btn_s3) btn_flag <= 1'b1;
      else if (btn_rd)       btn_flag <= 1'b0;
    end
  end
`else
  logic unused_btn_rd;
  assign unused_btn_rd = btn_rd;
  assign btn_bit       = btn_s2;
`endif

endmodule

// File: tb/tb_mmio_bus_unit.sv
// Directed bench for mmio_bus_unit: memory/IO reads, writes, ecalls, key, button, io_err, reset.
module tb_mmio_bus_unit;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_read, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        ecall_read, ecall_write;
  logic [11:0] ecall_op;
  logic [31:0] ecall_a0;
  logic        stall, rsp_valid;
  logic [31:0] rsp_data;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [11:0] switch_in;
  logic        btn_in, key_valid;
  logic [3:0]  key_code;
  logic [15:0] led_out;
  logic [31:0] seg_out;
  logic        io_err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  mmio_bus_unit dut (
    .clk(clk), .rst(rst),
    .req_read(req_read), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .ecall_read(ecall_read), .ecall_write(ecall_write), .ecall_op(ecall_op), .ecall_a0(ecall_a0),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .switch_in(switch_in), .btn_in(btn_in),
    .key_valid(key_valid), .key_code(key_code),
    .led_out(led_out), .seg_out(seg_out), .io_err(io_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    req_read = 0; req_write = 0; ecall_read = 0; ecall_write = 0; key_valid = 0;
  endtask

  // IO read: stall in the accept cycle only, response one cycle later.
  task automatic io_read(input string tag, input logic [7:0] o, input logic [31:0] exp);
    req_read = 1; req_addr = BASE | {24'd0, o};
    #1 chk({tag, "_stall"}, stall, 1);
    tick();
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_data"}, rsp_data, exp);
    chk({tag, "_stall_resp"}, stall, 0);
    req_read = 0;
    tick();
  endtask

  initial begin
    rst = 1; idle_bus();
    req_addr = 0; req_wdata = 0; ecall_op = 0; ecall_a0 = 0;
    mem_rdata = 0; switch_in = 0; btn_in = 0; key_code = 0;
    tick(); tick();
    chk("rst_stall", stall, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_led", led_out, 0);
    chk("rst_seg", seg_out, 0);
    chk("rst_err", io_err, 0);
    chk("rst_state", dbg_state, 0);
    rst = 0;
    tick();

    // Memory read, latency 2
    req_read = 1; req_addr = 32'h40; mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("mrd_stall_t0", stall, 1);
    chk("mrd_en_t0", mem_en, 1);
    chk("mrd_we_t0", mem_we, 0);
    chk("mrd_addr", mem_addr, 32'h40);
    tick();
    chk("mrd_stall_t1", stall, 1);
    chk("mrd_en_t1", mem_en, 0);
    chk("mrd_valid_t1", rsp_valid, 0);
    tick();
    chk("mrd_stall_t2", stall, 0);
    chk("mrd_en_t2", mem_en, 0);
    chk("mrd_valid_t2", rsp_valid, 1);
    chk("mrd_data", rsp_data, 32'hDEAD_BEEF);
    req_read = 0;
    tick();
    chk("mrd_valid_after", rsp_valid, 0);

    // Switch via IO and via ecall
    switch_in = 12'hABC;
    io_read("sw", 8'h00, 32'h0000_0ABC);
    ecall_read = 1; ecall_op = 12'd5;
    #1 chk("ecr_stall", stall, 1);
    tick();
    chk("ecr_valid", rsp_valid, 1);
    chk("ecr_data", rsp_data, 32'h0000_0ABC);
    ecall_read = 0;
    tick();

    // Writes
    req_write = 1; req_addr = BASE | 32'h10; req_wdata = 32'h0000_1234;
    #1;
    chk("ledw_stall", stall, 0);
    chk("ledw_en", mem_en, 0);
    tick();
    chk("ledw_led", led_out, 16'h1234);
    req_addr = BASE | 32'h14; req_wdata = 32'hCAFE_F00D;
    tick();
    chk("segw_seg", seg_out, 32'hCAFE_F00D);
    req_addr = 32'h80; req_wdata = 32'h11;
    #1;
    chk("mwr_en", mem_en, 1);
    chk("mwr_we", mem_we, 1);
    chk("mwr_wdata", mem_wdata, 32'h11);
    chk("mwr_stall", stall, 0);
    req_write = 0;
    tick();
    ecall_write = 1; ecall_op = 12'd1; ecall_a0 = 32'hABCD_0055;
    tick();
    chk("ecw_led", led_out, 16'h0055);
    ecall_write = 0;
    tick();

    // Keyboard
    key_valid = 1; key_code = 4'h7;
    tick();
    key_valid = 0;
    io_read("key1", 8'h08, 32'h17);
    io_read("key2", 8'h08, 32'h07);
    key_valid = 1; key_code = 4'h3;
    io_read("key_coinc", 8'h08, 32'h07);
    key_valid = 0;
    io_read("status", 8'h18, 32'h2);
    io_read("key3", 8'h08, 32'h13);

    // Button
    btn_in = 1;
    tick(); tick(); tick(); tick();
`ifdef MMIO_BTN_STICKY_EN
    btn_in = 0;
    tick(); tick(); tick(); tick();
    io_read("btn_sticky1", 8'h04, 32'h1);
    io_read("btn_sticky2", 8'h04, 32'h0);
`else
    io_read("btn_held", 8'h04, 32'h1);
    btn_in = 0;
    tick(); tick(); tick(); tick();
    io_read("btn_released", 8'h04, 32'h0);
`endif

    // Unmapped access
    chk("err_before", io_err, 0);
    io_read("unmapped", 8'h0C, 32'h0);
    chk("err_set", io_err, 1);
    req_write = 1; req_addr = BASE | 32'h20; req_wdata = 32'hFFFF;
    tick();
    req_write = 0;
    chk("unmapped_wr_led", led_out, 16'h0055);
    tick(); tick();
    chk("err_sticky", io_err, 1);

    // Reset during MEM_WAIT
    req_read = 1; req_addr = 32'h40;
    tick();
    chk("rstmid_wait", stall, 1);
    rst = 1; req_read = 0;
    #1;
    chk("rstmid_stall", stall, 0);
    chk("rstmid_valid", rsp_valid, 0);
    chk("rstmid_data", rsp_data, 0);
    chk("rstmid_led", led_out, 0);
    chk("rstmid_seg", seg_out, 0);
    chk("rstmid_err", io_err, 0);
    chk("rstmid_en", mem_en, 0);
    tick();
    rst = 0;
    tick();
    chk("rstmid_no_rsp1", rsp_valid, 0);
    tick();
    chk("rstmid_no_rsp2", rsp_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
